// File: rtl/csr_access_guard.sv
// csr_access_guard
// Checks each CSR access against the fixed debug / read-only / privilege
// rules and NUM_WIN lockable protection windows, and returns pass or an
// ILLEGAL_INSTR exception one cycle later on a valid/ready channel.
// Repeated consecutive faults push the block into LOCKDOWN, where every
// non-debug access faults until a debug-mode access releases it.
module csr_access_guard #(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 12,
    parameter int NUM_WIN     = 4,
    parameter int CNT_W       = 16,
    parameter int LOCK_THRESH = 4,
    localparam int IDX_W      = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_we_i,
    input  logic              req_re_i,
    input  logic [1:0]        priv_lvl_i,
    input  logic              debug_mode_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic              resp_ex_valid_o,
    output logic [XLEN-1:0]   resp_ex_cause_o,
    output logic [XLEN-1:0]   resp_ex_tval_o,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [ADDR_W-1:0] cfg_mask_i,
    input  logic              cfg_dbg_only_i,
    input  logic              cfg_lock_i,
    output logic [CNT_W-1:0]  viol_cnt_o,
    output logic              lockdown_o
);

    localparam int CONS_W = $clog2(LOCK_THRESH + 1);
    localparam logic [CONS_W-1:0] THRESH = CONS_W'(LOCK_THRESH);
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSTR = XLEN'(2);

    typedef enum logic {
        ST_NORMAL   = 1'b0,
        ST_LOCKDOWN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CONS_W-1:0] consec_q, consec_d;
    logic [CNT_W-1:0]  viol_q, viol_d;

    logic              resp_valid_q;
    logic              resp_ex_q;
    logic [ADDR_W-1:0] resp_tval_q;

    logic [NUM_WIN-1:0] win_en_q;
    logic [NUM_WIN-1:0] win_dbg_q;
    logic [NUM_WIN-1:0] win_lock_q;
    logic [ADDR_W-1:0]  win_base_q [NUM_WIN];
    logic [ADDR_W-1:0]  win_mask_q [NUM_WIN];
    logic [NUM_WIN-1:0] win_wr;

    logic accept;
    logic is_access;
    logic win_fault;
    logic fault;

    assign req_ready_o = !resp_valid_q || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign is_access   = req_we_i || req_re_i;

    // Decode which window (if any) a cfg write targets; locked windows refuse it.
    always_comb begin
        win_wr = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            win_wr[w] = cfg_we_i && (int'(cfg_idx_i) == w) && !win_lock_q[w];
        end
    end

    // A debug-only window faults any non-debug access whose masked address matches.
    always_comb begin
        win_fault = 1'b0;
        for (int w = 0; w < NUM_WIN; w++) begin
            if (win_en_q[w] && win_dbg_q[w] &&
                ((req_addr_i & win_mask_q[w]) == (win_base_q[w] & win_mask_q[w]))) begin
                win_fault = 1'b1;
            end
        end
    end

    // Combine all fault rules; only real reads/writes can fault.
    always_comb begin
        fault = 1'b0;
        if (is_access) begin
            if (!debug_mode_i && (req_addr_i[11:4] == 8'h7b))   fault = 1'b1;
            if (req_we_i && (req_addr_i[11:10] == 2'b11))       fault = 1'b1;
            if (!debug_mode_i && (req_addr_i[9:8] > priv_lvl_i)) fault = 1'b1;
            if (!debug_mode_i && win_fault)                      fault = 1'b1;
            if (!debug_mode_i && (state_q == ST_LOCKDOWN))       fault = 1'b1;
        end
    end

    // Next-state logic for the lockdown FSM and the two violation counters.
    always_comb begin
        logic [CONS_W-1:0] consec_base;
        logic [CONS_W-1:0] consec_inc;
        state_d     = state_q;
        consec_d    = consec_q;
        viol_d      = viol_q;
        consec_base = consec_q;
        consec_inc  = consec_q;
        if (accept && is_access) begin
            // A debug access releases lockdown and is then judged as in NORMAL.
            if ((state_q == ST_LOCKDOWN) && debug_mode_i) begin
                state_d     = ST_NORMAL;
                consec_base = '0;
            end
            if (fault) begin
                viol_d     = (viol_q == '1) ? viol_q : viol_q + 1'b1;
                consec_inc = (consec_base == THRESH) ? consec_base : consec_base + 1'b1;
                consec_d   = consec_inc;
                if (consec_inc == THRESH) begin
                    state_d = ST_LOCKDOWN;
                end
            end else begin
                consec_d = '0;
            end
        end
    end

    // FSM, counters and the registered response slot.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            state_q      <= ST_NORMAL;
            consec_q     <= '0;
            viol_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_ex_q    <= 1'b0;
            resp_tval_q  <= '0;
        end else begin
            state_q  <= state_d;
            consec_q <= consec_d;
            viol_q   <= viol_d;
            if (accept) begin
                resp_valid_q <= 1'b1;
                resp_ex_q    <= fault;
                resp_tval_q  <= fault ? req_addr_i : '0;
            end else if (resp_ready_i) begin
                resp_valid_q <= 1'b0;
                resp_ex_q    <= 1'b0;
                resp_tval_q  <= '0;
            end
        end
    end

    // Window control bits: enabled by the first write, locked until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_en_q   <= '0;
            win_dbg_q  <= '0;
            win_lock_q <= '0;
        end else begin
            for (int w = 0; w < NUM_WIN; w++) begin
                if (win_wr[w]) begin
                    win_en_q[w]   <= 1'b1;
                    win_dbg_q[w]  <= cfg_dbg_only_i;
                    win_lock_q[w] <= cfg_lock_i;
                end
            end
        end
    end

    // Window base/mask storage.
    always_ff @(posedge clk_i) begin
        // NOTE: base/mask are not reset; they are ignored until win_en_q is set,
        // which is reset, so clearing them would only add reset fan-out.
        for (int w = 0; w < NUM_WIN; w++) begin
            if (win_wr[w]) begin
                win_base_q[w] <= cfg_base_i;
                win_mask_q[w] <= cfg_mask_i;
            end
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_ex_valid_o = resp_ex_q;
    assign resp_ex_cause_o = resp_ex_q ? CAUSE_ILLEGAL_INSTR : '0;
    assign resp_ex_tval_o  = XLEN'(resp_tval_q);
    assign viol_cnt_o      = viol_q;
    assign lockdown_o      = (state_q == ST_LOCKDOWN);

endmodule
